// File: rtl/mole_round_engine.sv
// mole_round_engine: whack-a-mole round sequencer.
// Each round draws a box from a free-running LFSR and opens a timed hit window.
// It then scores the correct hit, the wrong hit or the expiry (a miss). The
// level rises with play time, which halves the window and doubles the points
// per hit.
//
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   go             start a game from IDLE or GAME_OVER (level-sensitive)
//   hit_valid      one-cycle strobe from the box decoder
//   box_address    struck box index, qualified by hit_valid
//   board_out      one-hot active box, zero outside ACTIVE
//   round_start    pulse in the first ACTIVE cycle of a round
//   audio_en       pulse on a correct hit
//   score          saturating score, floored at zero
//   level          difficulty 1..3
//   misses         expired windows this game
//   game_over      high while in GAME_OVER
module mole_round_engine #(
   parameter int                NUM_BOXES   = 9,
   parameter int                BOX_AW      = 4,
   parameter int                SCORE_W     = 11,
   parameter int                LFSR_W      = 10,
   parameter logic [LFSR_W-1:0] LFSR_SEED   = LFSR_W'('h2A5),
   parameter int                WINDOW_BASE = 48_000_000,
   parameter int                LEVEL_TICKS = 20_000_000,
   parameter int                MAX_MISSES  = 5
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 go,
   input  logic                 hit_valid,
   input  logic [BOX_AW-1:0]    box_address,
   output logic [NUM_BOXES-1:0] board_out,
   output logic                 round_start,
   output logic                 audio_en,
   output logic [SCORE_W-1:0]   score,
   output logic [1:0]           level,
   output logic [3:0]           misses,
   output logic                 game_over
);

   typedef enum logic [2:0] {
      S_IDLE, S_SPAWN, S_ACTIVE, S_RESOLVE, S_GAME_OVER
   } state_t;

   // Maximal-length Fibonacci tap masks (bit n-1 for tap n), widths 4..16.
   function automatic logic [31:0] tap_mask(input int width);
      case (width)
         4:       return 32'h0000_000C;
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         8:       return 32'h0000_00B8;
         9:       return 32'h0000_0110;
         11:      return 32'h0000_0500;
         12:      return 32'h0000_0829;
         13:      return 32'h0000_100D;
         14:      return 32'h0000_2015;
         15:      return 32'h0000_6000;
         16:      return 32'h0000_D008;
         default: return 32'h0000_0240;
      endcase
   endfunction

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
      logic [SCORE_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
   endfunction

   function automatic logic [SCORE_W-1:0] floor_sub(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
      logic signed [SCORE_W:0] diff;
      diff = $signed({1'b0, a}) - $signed({1'b0, b});
      return diff[SCORE_W] ? '0 : diff[SCORE_W-1:0];
   endfunction

   localparam int                  WIN_W      = $clog2(WINDOW_BASE + 1);
   localparam int                  TICK_W     = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;
   localparam logic [31:0]         TAP_MASK   = tap_mask(LFSR_W);
   localparam logic [LFSR_W-1:0]   TAPS       = TAP_MASK[LFSR_W-1:0];
   localparam logic [WIN_W-1:0]    WIN_BASE   = WIN_W'(WINDOW_BASE);
   localparam logic [TICK_W-1:0]   TICK_LAST  = TICK_W'(LEVEL_TICKS - 1);
   localparam logic [BOX_AW:0]     NO_BOX     = (BOX_AW + 1)'(NUM_BOXES);
   localparam logic [3:0]          MISS_LIMIT = 4'(MAX_MISSES);
   localparam logic [NUM_BOXES-1:0] ONE       = NUM_BOXES'(1);

   state_t                 state, state_nxt;
   logic [LFSR_W-1:0]      lfsr;
   logic [BOX_AW-1:0]      active_box, cand;
   logic [BOX_AW:0]        prev_box;   // one bit wider so NUM_BOXES can mean "none"
   logic [WIN_W-1:0]       win_cnt, win_load;
   logic [TICK_W-1:0]      play_tick;
   logic [SCORE_W-1:0]     points;
   logic                   cand_ok, hit_ok, hit_bad, expire, start, playing;
   logic [NUM_BOXES-1:0]   board_nxt;
   logic                   round_start_nxt, audio_nxt, game_over_nxt;

   assign cand     = lfsr[BOX_AW-1:0];
   assign cand_ok  = ({1'b0, cand} < NO_BOX) && ({1'b0, cand} != prev_box);
   assign hit_ok   = (state == S_ACTIVE) && hit_valid && (box_address == active_box);
   assign hit_bad  = (state == S_ACTIVE) && hit_valid && (box_address != active_box);
   // The counter is loaded with W-1, so reaching zero marks the W-th ACTIVE cycle.
   assign expire   = (state == S_ACTIVE) && (win_cnt == '0);
   assign start    = ((state == S_IDLE) || (state == S_GAME_OVER)) && go;
   assign playing  = (state == S_SPAWN) || (state == S_ACTIVE) || (state == S_RESOLVE);
   assign points   = SCORE_W'(1) << level;
   assign win_load = (WIN_BASE >> (level - 2'd1)) - WIN_W'(1);

   // State register
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (go) state_nxt = S_SPAWN;
         S_SPAWN:     if (cand_ok) state_nxt = S_ACTIVE;
         S_ACTIVE:    if (hit_ok || expire) state_nxt = S_RESOLVE;
         S_RESOLVE:   state_nxt = (misses >= MISS_LIMIT) ? S_GAME_OVER : S_SPAWN;
         S_GAME_OVER: if (go) state_nxt = S_SPAWN;
         default:     state_nxt = S_IDLE;
      endcase
   end

   // Output logic, registered below so every output lines up with the state
   always_comb begin
      board_nxt       = '0;
      round_start_nxt = 1'b0;
      audio_nxt       = hit_ok;
      game_over_nxt   = (state_nxt == S_GAME_OVER);
      if ((state == S_SPAWN) && cand_ok) begin
         board_nxt       = ONE << cand;
         round_start_nxt = 1'b1;
      end else if ((state == S_ACTIVE) && (state_nxt == S_ACTIVE)) begin
         board_nxt = ONE << active_box;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr        <= LFSR_SEED;
         prev_box    <= NO_BOX;
         active_box  <= '0;
         win_cnt     <= '0;
         play_tick   <= '0;
         score       <= '0;
         level       <= 2'd1;
         misses      <= '0;
         board_out   <= '0;
         round_start <= 1'b0;
         audio_en    <= 1'b0;
         game_over   <= 1'b0;
      end else begin
         lfsr        <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
         board_out   <= board_nxt;
         round_start <= round_start_nxt;
         audio_en    <= audio_nxt;
         game_over   <= game_over_nxt;
         if (start) begin
            // The play timer restarts with the game so level 1 lasts a full step.
            score     <= '0;
            level     <= 2'd1;
            misses    <= '0;
            play_tick <= '0;
         end else begin
            if (playing) begin
               if (play_tick == TICK_LAST) begin
                  play_tick <= '0;
                  if (level != 2'd3) level <= level + 2'd1;
               end else begin
                  play_tick <= play_tick + TICK_W'(1);
               end
            end
            if ((state == S_SPAWN) && cand_ok) begin
               active_box <= cand;
               prev_box   <= {1'b0, cand};
               win_cnt    <= win_load;
            end else if ((state == S_ACTIVE) && (win_cnt != '0)) begin
               win_cnt <= win_cnt - WIN_W'(1);
            end
            if (hit_ok)       score <= sat_add(score, points);
            else if (hit_bad) score <= floor_sub(score, points);
            // A correct hit in the last window cycle takes priority over the miss.
            if (expire && !hit_ok) misses <= misses + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_mole_round_engine.sv
module tb_mole_round_engine;
   localparam int NB = 9;
   localparam int AW = 4;
   localparam int SW = 11;
   localparam int WB = 16;
   localparam int LT = 200;
   localparam int MM = 3;
   localparam int SEED_I = 'h2A5;
   localparam int P_IDLE = 0, P_SPAWN = 1, P_ACT = 2, P_RES = 3, P_OVER = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          go = 1'b0;
   logic          hit_valid = 1'b0;
   logic [AW-1:0] box_address = '0;
   logic [NB-1:0] board_out;
   logic          round_start, audio_en, game_over;
   logic [SW-1:0] score;
   logic [1:0]    level;
   logic [3:0]    misses;

   mole_round_engine #(
      .NUM_BOXES(NB), .BOX_AW(AW), .SCORE_W(SW), .LFSR_W(10), .LFSR_SEED(10'h2A5),
      .WINDOW_BASE(WB), .LEVEL_TICKS(LT), .MAX_MISSES(MM)
   ) dut (
      .clock(clock), .reset(reset), .go(go), .hit_valid(hit_valid),
      .box_address(box_address), .board_out(board_out), .round_start(round_start),
      .audio_en(audio_en), .score(score), .level(level), .misses(misses),
      .game_over(game_over)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural reference: game phase, remaining window, total play cycles.
   int m_ph = P_IDLE, m_lfsr = SEED_I, m_prev = NB, m_box = 0, m_left = 0;
   int m_score = 0, m_miss = 0, m_play = 0, m_loadlev = 1;
   bit e_rs = 1'b0, e_au = 1'b0;

   function automatic int model_level();
      int steps;
      steps = m_play / LT;
      return 1 + ((steps > 2) ? 2 : steps);
   endfunction

   task automatic model_step(input bit r, input bit g, input bit hv, input int ba);
      int lev, c, pts;
      if (r) begin
         m_ph = P_IDLE; m_lfsr = SEED_I; m_prev = NB; m_score = 0; m_miss = 0;
         m_play = 0; e_rs = 1'b0; e_au = 1'b0;
         return;
      end
      lev = model_level();
      pts = 1 << lev;
      e_rs = 1'b0;
      e_au = 1'b0;
      if (m_ph == P_SPAWN || m_ph == P_ACT || m_ph == P_RES) m_play++;
      case (m_ph)
         P_IDLE, P_OVER: if (g) begin
            m_score = 0; m_miss = 0; m_play = 0; m_ph = P_SPAWN;
         end
         P_SPAWN: begin
            c = m_lfsr % 16;
            if (c < NB && c != m_prev) begin
               m_box = c; m_prev = c; m_left = WB >> (lev - 1); m_loadlev = lev;
               m_ph = P_ACT; e_rs = 1'b1;
            end
         end
         P_ACT: begin
            if (hv && ba == m_box) begin
               m_score = (m_score + pts > 2047) ? 2047 : m_score + pts;
               e_au = 1'b1;
               m_ph = P_RES;
            end else begin
               if (hv) m_score = (m_score > pts) ? m_score - pts : 0;
               m_left--;
               if (m_left == 0) begin
                  m_miss++;
                  m_ph = P_RES;
               end
            end
         end
         P_RES: m_ph = (m_miss >= MM) ? P_OVER : P_SPAWN;
         default: m_ph = P_IDLE;
      endcase
      m_lfsr = ((m_lfsr << 1) & 'h3FF) | (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_outputs();
      logic [NB-1:0] eb;
      logic [1:0]    el;
      logic          eo;
      eb = (m_ph == P_ACT) ? (NB'(1) << m_box) : '0;
      el = 2'(model_level());
      eo = (m_ph == P_OVER);
      n_checks++;
      if (board_out !== eb || round_start !== e_rs || audio_en !== e_au ||
          score !== SW'(m_score) || level !== el || misses !== 4'(m_miss) ||
          game_over !== eo) begin
         n_fail++;
         $display("FAIL cycle_outputs t=%0t: got board=%b rs=%b au=%b score=%0d lvl=%0d miss=%0d over=%b; expected board=%b rs=%b au=%b score=%0d lvl=%0d miss=%0d over=%b",
                  $time, board_out, round_start, audio_en, score, level, misses, game_over,
                  eb, e_rs, e_au, m_score, el, m_miss, eo);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_step(reset, go, hit_valid, int'(box_address));
      #1;
      cmp_outputs();
   endtask

   function automatic int dut_box(input logic [NB-1:0] b);
      for (int i = 0; i < NB; i++) if (b[i]) return i;
      return -1;
   endfunction

   task automatic wait_round(input string tag, output int k);
      k = 0;
      while (round_start !== 1'b1 && k < 64) begin
         tick();
         k++;
      end
      n_checks++;
      if (round_start !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: round_start not seen within 64 cycles", tag);
      end
   endtask

   // Entered in ACTIVE cycle 1; cycles are numbered from 1, 0 means "no action".
   task automatic play_round(input int wrong_at, input int wrong_addr, input int hit_at,
                             input int exp_w, output int len);
      int cyc, box;
      box = m_box;
      cyc = 1;
      while (board_out != '0 && cyc <= 40) begin
         if (cyc == hit_at) begin
            hit_valid = 1'b1; box_address = AW'(box);
         end else if (cyc == wrong_at) begin
            hit_valid = 1'b1;
            box_address = (wrong_addr < 0) ? AW'((box + 1) % NB) : AW'(wrong_addr);
         end
         tick();
         hit_valid = 1'b0;
         if (cyc == hit_at) check("audio_on_hit", audio_en, 1);
         if (cyc == wrong_at && exp_w >= 0) check("score_after_wrong_hit", score, exp_w);
         cyc++;
      end
      len = cyc - 1;
   endtask

   typedef struct {
      int wrong_at;   int wrong_addr; int hit_at; int exp_w;
      int exp_len;    int exp_score;  int exp_miss;
   } row_t;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      row_t rows[7];
      int k, len, first_box, prev_box, cur, stage, extra, s0;

      rows[0] = '{2, -1, 3, 0, 3, 2, 0};     // wrong hit at score 0, correct on cycle 3
      rows[1] = '{0, -1, 1, -1, 1, 4, 0};
      rows[2] = '{0, -1, 16, -1, 16, 6, 0};  // correct hit in final window cycle
      rows[3] = '{2, 12, 5, 4, 5, 6, 0};     // out-of-range index counts as wrong
      rows[4] = '{1, -1, 0, 4, 16, 4, 1};
      rows[5] = '{0, -1, 0, -1, 16, 4, 2};
      rows[6] = '{16, -1, 0, 2, 16, 2, 3};   // wrong hit together with expiry

      repeat (3) tick();
      check("reset_board", board_out, 0);
      check("reset_score", score, 0);
      check("reset_level", level, 1);
      check("reset_game_over", game_over, 0);
      reset = 1'b0;
      tick(); tick();
      go = 1'b1; tick(); go = 1'b0;
      wait_round("first_round", k);
      check("first_spawn_within_16", k <= 16, 1);
      check("first_level", level, 1);
      first_box = m_box;
      prev_box = -1;

      for (int i = 0; i < 7; i++) begin
         if (i > 0) wait_round("table_round", k);
         cur = dut_box(board_out);
         check("board_onehot", $onehot(board_out), 1);
         if (prev_box >= 0) check("box_differs_from_previous", cur != prev_box, 1);
         prev_box = cur;
         play_round(rows[i].wrong_at, rows[i].wrong_addr, rows[i].hit_at, rows[i].exp_w, len);
         check("active_length", len, rows[i].exp_len);
         check("round_score", score, rows[i].exp_score);
         check("round_misses", misses, rows[i].exp_miss);
      end

      tick();
      check("game_over_set", game_over, 1);
      check("game_over_board", board_out, 0);
      for (int i = 0; i < 4; i++) begin
         hit_valid = 1'b1; box_address = AW'(i);
         tick();
      end
      hit_valid = 1'b0;
      check("hits_ignored_in_game_over", score, 2);
      go = 1'b1; tick(); go = 1'b0;
      check("restart_score", score, 0);
      check("restart_misses", misses, 0);
      check("restart_game_over", game_over, 0);

      stage = 0;
      extra = 0;
      for (int r = 0; r < 400 && stage < 5; r++) begin
         wait_round("level_round", k);
         s0 = m_score;
         case (stage)
            0: if (m_loadlev == 2) begin
                  play_round(0, -1, 0, -1, len);
                  check("level2_window", len, 8);
                  stage = 1;
               end else play_round(0, -1, 1, -1, len);
            1: begin
                  play_round(0, -1, 1, -1, len);
                  check("level2_points", score, s0 + 4);
                  stage = 2;
               end
            2: if (m_loadlev == 3) begin
                  play_round(0, -1, 0, -1, len);
                  check("level3_window", len, 4);
                  stage = 3;
               end else play_round(0, -1, 1, -1, len);
            3: begin
                  play_round(0, -1, 1, -1, len);
                  check("level3_points", score, s0 + 8);
                  stage = 4;
               end
            default: begin
                  play_round(0, -1, 1, -1, len);
                  extra++;
                  if (extra == 5) begin
                     check("level_capped_at_3", level, 3);
                     stage = 5;
                  end
               end
         endcase
      end
      check("level_progress_reached", stage, 5);

      wait_round("reset_round", k);
      tick(); tick();
      reset = 1'b1; tick();
      check("midround_reset_board", board_out, 0);
      check("midround_reset_rs", round_start, 0);
      check("midround_reset_audio", audio_en, 0);
      check("midround_reset_score", score, 0);
      check("midround_reset_level", level, 1);
      check("midround_reset_misses", misses, 0);
      check("midround_reset_over", game_over, 0);
      reset = 1'b0;
      tick(); tick();
      go = 1'b1; tick(); go = 1'b0;
      wait_round("replay_round", k);
      check("lfsr_replay_box", dut_box(board_out), first_box);

      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 499) == 0);
         go = ($urandom_range(0, 3) == 0);
         hit_valid = ($urandom_range(0, 3) == 0);
         box_address = ($urandom_range(0, 1) == 0) ? AW'(m_box) : AW'($urandom_range(0, 15));
         tick();
      end
      reset = 1'b0; go = 1'b0; hit_valid = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
